alu_arb_ctrl: RTL and testbench

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_ctrl_pkg.sv | 35 +++
 rtl/rr_arb2.sv | 31 +++
 rtl/alu_arb_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_arb_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the arbitrated ALU controller.
package alu_ctrl_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned OP_W   = 4;

  // Bit positions inside the {z,c,o,G,L,E} flag vector
  localparam int unsigned FLAG_Z = 5;
  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_G = 2;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_E = 0;

  // Unit-select code that no ALU unit decodes
  localparam logic [1:0] UNIT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op[1:0] == UNIT_ILLEGAL;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester not served last has priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic [1:0] grant,
  output logic       prio
);

  // Priority moves to the other requester when a response completes
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (advance) begin
      prio <= ~served;
    end
  end

  // Priority requester wins; otherwise the single active requester
  always_comb begin
    grant = 2'b00;
    if (req[prio]) begin
      grant[prio] = 1'b1;
    end else if (req[~prio]) begin
      grant[~prio] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Arbitrates two requesters onto one registered-result ALU and returns
// the captured result/flags through a valid/ready response port.
module alu_arb_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic [5:0]  rsp_flags,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_f,
  input  logic [5:0]  alu_flags,
  output logic        busy
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] grant;
  logic       prio;
  logic       accept;
  logic       acc_id;
  logic       advance;
  alu_req_t   sel_req;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .served  (rsp_id),
    .grant   (grant),
    .prio    (prio)
  );

  assign busy    = (state_q != ST_IDLE);
  assign advance = (state_q == ST_RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, request acceptance and winner operand selection
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    if (!rst && (state_q == ST_IDLE)) begin
      req_ready = grant;
    end
    accept     = |(req_valid & req_ready);
    acc_id     = req_ready[1];
    sel_req.a  = acc_id ? req_a[15:8] : req_a[7:0];
    sel_req.b  = acc_id ? req_b[15:8] : req_b[7:0];
    sel_req.op = acc_id ? req_op[7:4] : req_op[3:0];
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = op_illegal(sel_req.op) ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand issue and response capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_flags <= 6'h00;
      rsp_err   <= 1'b0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_sel   <= 4'h0;
    end else begin
      rsp_valid <= (state_d == ST_RESP);
      if (accept) begin
        rsp_id <= acc_id;
        if (op_illegal(sel_req.op)) begin
          rsp_err   <= 1'b1;
          rsp_data  <= 8'h00;
          rsp_flags <= 6'h00;
        end else begin
          rsp_err <= 1'b0;
          alu_a   <= sel_req.a;
          alu_b   <= sel_req.b;
          alu_sel <= sel_req.op;
        end
      end
      if (state_q == ST_EXEC) begin
        rsp_flags <= alu_flags;
      end
      if (state_q == ST_WAIT) begin
        rsp_data <= alu_f;
      end
    end
  end

  // When both requesters ask, the winner must be the priority requester
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_IDLE) && (req_valid == 2'b11)) begin
      assert (req_ready[prio]);
    end
  end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Scoreboard bench for alu_arb_ctrl with a behavioural ALU and arbitration model.
module tb_alu_arb_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic [5:0]  rsp_flags;
  logic        rsp_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_f = 8'h00;
  logic [5:0]  alu_flags;
  logic        busy;

  alu_arb_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_f(alu_f), .alu_flags(alu_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } tx_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic [5:0] flags;
    logic       err;
    int         lat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  tx_t  pend[2][$];
  exp_t sbq[$];
  logic acc_log[$];
  int   acc_cnt[2];
  int   popped[2];
  int   rsp_cnt = 0;
  logic outstanding = 1'b0;
  logic prio_m = 1'b0;
  logic was_valid = 1'b0;
  int   acc_cyc = 0;
  bit   drop_en = 1'b0;
  int   rsp_mode = 0;
  logic       last_id;
  logic [7:0] last_data;
  logic [5:0] last_flags;
  logic       last_err;

  // Behavioural ALU: {F, z,c,o,G,L,E}
  function automatic logic [13:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
    logic [8:0] r;
    logic [7:0] f;
    logic [5:0] fl;
    r  = 9'd0;
    fl = 6'd0;
    case (s[1:0])
      2'b00: begin
        case (s[3:2])
          2'b00: r = {1'b0, a} + {1'b0, b};
          2'b01: r = {1'b0, a} - {1'b0, b};
          2'b10: r = {1'b0, a} + 9'd1;
          default: r = {1'b0, a} - 9'd1;
        endcase
      end
      2'b01: begin
        case (s[3:2])
          2'b00: r = {1'b0, a & b};
          2'b01: r = {1'b0, a | b};
          2'b10: r = {1'b0, a ^ b};
          default: r = {1'b0, ~a};
        endcase
      end
      2'b10: begin
        case (s[3:2])
          2'b00: r = {a, 1'b0};
          2'b01: r = {1'b0, 1'b0, a[7:1]};
          2'b10: r = {1'b0, a[6:0], a[7]};
          default: r = {1'b0, a[0], a[7:1]};
        endcase
      end
      default: r = 9'd0;
    endcase
    f = r[7:0];
    fl[FLAG_Z] = (f == 8'h00);
    fl[FLAG_C] = r[8];
    if (s == 4'b0000) fl[FLAG_O] = (a[7] == b[7]) && (f[7] != a[7]);
    if (s == 4'b0100) fl[FLAG_O] = (a[7] != b[7]) && (f[7] != a[7]);
    fl[FLAG_G] = (a > b);
    fl[FLAG_L] = (a < b);
    fl[FLAG_E] = (a == b);
    return {f, fl};
  endfunction

  logic [13:0] alu_now;
  assign alu_now   = alu_calc(alu_a, alu_b, alu_sel);
  assign alu_flags = alu_now[5:0];
  always @(posedge clk) alu_f <= alu_now[13:6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requester and consumer driver
  initial begin
    tx_t t;
    req_valid = 2'b00;
    req_a = 16'h0; req_b = 16'h0; req_op = 8'h0;
    rsp_ready = 1'b1;
    popped[0] = 0; popped[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        while (popped[n] < acc_cnt[n]) begin
          if (pend[n].size() > 0) t = pend[n].pop_front();
          popped[n]++;
        end
        if (pend[n].size() > 0) begin
          req_valid[n] = drop_en ? ($urandom_range(0, 3) != 0) : 1'b1;
          req_a[8*n +: 8]  = pend[n][0].a;
          req_b[8*n +: 8]  = pend[n][0].b;
          req_op[4*n +: 4] = pend[n][0].op;
        end else begin
          req_valid[n] = 1'b0;
          req_a[8*n +: 8]  = 8'($urandom);
          req_b[8*n +: 8]  = 8'($urandom);
          req_op[4*n +: 4] = 4'($urandom);
        end
      end
      case (rsp_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'b0;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: arbitration model, acceptance capture and response scoreboard
  logic [1:0]  exp_rdy;
  logic        mid;
  logic [13:0] mres;
  logic [3:0]  mop;
  exp_t        me;
  initial begin
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        outstanding = 1'b0;
        prio_m = 1'b0;
        was_valid = 1'b0;
        chk("ready_in_reset", 32'(req_ready), 32'd0);
      end else begin
        if (outstanding) exp_rdy = 2'b00;
        else if (req_valid == 2'b11) exp_rdy = prio_m ? 2'b10 : 2'b01;
        else exp_rdy = req_valid;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(outstanding));
        if (|(req_valid & req_ready)) begin
          mid  = req_ready[1];
          mop  = mid ? req_op[7:4] : req_op[3:0];
          mres = alu_calc(mid ? req_a[15:8] : req_a[7:0], mid ? req_b[15:8] : req_b[7:0], mop);
          me.id = mid;
          if (mop[1:0] == 2'b11) begin
            me.err = 1'b1; me.data = 8'h00; me.flags = 6'h00; me.lat = 1;
          end else begin
            me.err = 1'b0; me.data = mres[13:6]; me.flags = mres[5:0]; me.lat = 3;
          end
          sbq.push_back(me);
          outstanding = 1'b1;
          acc_cyc = cyc;
          acc_cnt[mid]++;
          acc_log.push_back(mid);
        end
        if (rsp_valid) begin
          if (sbq.size() == 0) begin
            chk("spurious_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            me = sbq[0];
            chk("rsp_id", 32'(rsp_id), 32'(me.id));
            chk("rsp_data", 32'(rsp_data), 32'(me.data));
            chk("rsp_flags", 32'(rsp_flags), 32'(me.flags));
            chk("rsp_err", 32'(rsp_err), 32'(me.err));
            if (!was_valid) chk("latency", 32'(cyc - acc_cyc), 32'(me.lat));
            if (rsp_ready) begin
              me = sbq.pop_front();
              outstanding = 1'b0;
              prio_m = ~me.id;
              rsp_cnt++;
              last_id = rsp_id; last_data = rsp_data;
              last_flags = rsp_flags; last_err = rsp_err;
            end
          end
        end
        was_valid = rsp_valid && !rsp_ready;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pend[0].size() != 0 || pend[1].size() != 0 || sbq.size() != 0 || outstanding)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) chk("timeout_idle", 32'(n), 32'(budget - 1));
    repeat (3) @(posedge clk);
  endtask

  task automatic push_tx(input int n, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    tx_t t;
    t.a = a; t.b = b; t.op = op;
    pend[n].push_back(t);
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    int n;
    int base;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single add from requester 0
    push_tx(0, 8'h05, 8'h03, 4'b0000);
    wait_idle(100);
    chk("single_id", 32'(last_id), 32'd0);
    chk("single_data", 32'(last_data), 32'h08);
    chk("single_flags", 32'(last_flags), 32'b000100);

    // Illegal opcode from requester 1
    push_tx(1, 8'h77, 8'h11, 4'b0011);
    wait_idle(100);
    chk("illegal_err", 32'(last_err), 32'd1);
    chk("illegal_id", 32'(last_id), 32'd1);
    chk("illegal_data", 32'(last_data), 32'd0);
    chk("illegal_flags", 32'(last_flags), 32'd0);

    // Contention with both requesters held valid
    acc_log.delete();
    for (int i = 0; i < 2; i++) begin
      push_tx(0, 8'($urandom), 8'($urandom), 4'b0100);
      push_tx(1, 8'($urandom), 8'($urandom), 4'b1001);
    end
    wait_idle(200);
    chk("rr_count", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < acc_log.size(); i++) chk("rr_order", 32'(acc_log[i]), 32'(i % 2));

    // Backpressure in RESP with a second request waiting
    rsp_mode = 1;
    base = rsp_cnt;
    push_tx(1, 8'hC0, 8'h50, 4'b0000);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); n++; end
    if (n >= 50) chk("timeout_bp", 32'(n), 32'd0);
    push_tx(0, 8'h10, 8'h10, 4'b0001);
    repeat (5) @(posedge clk);
    chk("bp_held", 32'(rsp_cnt - base), 32'd0);
    rsp_mode = 0;
    wait_idle(100);
    chk("bp_delivered", 32'(rsp_cnt - base), 32'd2);

    // Reset while the ALU result is pending
    base = acc_cnt[0];
    push_tx(0, 8'h21, 8'h12, 4'b0000);
    n = 0;
    while (acc_cnt[0] == base && n < 50) begin @(posedge clk); n++; end
    if (n >= 50) chk("timeout_acc", 32'(n), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    base = rsp_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    chk("midrst_no_rsp", 32'(rsp_cnt - base), 32'd0);
    acc_log.delete();
    push_tx(0, 8'h01, 8'h02, 4'b0000);
    push_tx(1, 8'h03, 8'h04, 4'b0000);
    wait_idle(100);
    chk("midrst_prio0", 32'(acc_log[0]), 32'd0);

    // Randomized traffic with withdrawals and random consumer stalls
    drop_en = 1'b1;
    rsp_mode = 2;
    for (int i = 0; i < 60; i++) begin
      push_tx(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'($urandom));
    end
    wait_idle(5000);
    drop_en = 1'b0;
    rsp_mode = 0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
